packet_admission_dispatch: RTL and testbench
============================================

# packet_admission_dispatch

Parametrised successor of the host-side packet map/dispatch front end. Sits between the host receive byte stream and input buffer management. Classifies each packet by its control word and polices time-sensitive (TS) flows against a per-period packet budget over `FLOW_NUM` flows. Applies free-buffer thresholds to RC/BE traffic, splits NMAC traffic onto its own port, and forwards admitted packets with fixed one-cycle latency.

## Interface
- `FLOW_NUM`, default 32: number of TS flows policed; must be a power of two, 2..256.
- `FLOW_ID_W`, default 5: log2(`FLOW_NUM`).
- `CNT_W`, default 8: width of per-flow packet counters and limit.
- `i_clk`  in  1  single clock.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `iv_data`  in  9  byte stream; bit8=1 marks head and tail bytes.
- `i_data_wr`  in  1  byte valid.
- `iv_ctrl_data`  in  19  sampled on head byte; [18:16] type (000 TS, 001 RC, 010 BE, 011 NMAC, others treated as BE); [FLOW_ID_W-1:0] flow id.
- `i_period_sync`  in  1  one-cycle pulse, starts a new policing period.
- `iv_ts_limit`  in  CNT_W  max TS packets per flow per period (global limit).
- `iv_free_bufid_fifo_rdusedw`  in  9  free buffer ids available.
- `iv_rc_threshold_value`, `iv_be_threshold_value`  in  9  each  admit RC/BE only if rdusedw > threshold.
- `ov_data`  out  9  admitted TS/RC/BE byte.
- `o_data_wr`  out  1  byte valid.
- `ov_ctrl_data`  out  19  control word of the current packet, held from head to tail.
- `ov_nmac_data`  out  9  NMAC byte.
- `o_nmac_data_wr`  out  1  NMAC byte valid.
- `o_pkt_cnt_pulse`  out  1  one pulse per head received.
- `o_pkt_discard_pulse`  out  1  one pulse per dropped packet.
- `o_ts_overflow_error_pulse`  out  1  one pulse per TS packet dropped for budget.
- `ov_overflow_flow_id`  out  FLOW_ID_W  flow id of the last TS overflow.
- `ov_pad_state`  out  2  FSM state for debug.

## Operation
- FSM states: IDLE(00), FWD(01), NMAC(10), DROP(11).
- IDLE: on `i_data_wr` with bit8=1 (head), decide the packet:
  - NMAC goes to NMAC.
  - TS: if cnt[flow] < limit, increment cnt and go to FWD; otherwise go to DROP with an overflow pulse.
  - RC/BE: FWD if rdusedw > threshold, else DROP.
- Bytes with bit8=0 in IDLE are ignored (no pulses).
- FWD/NMAC/DROP: pass (or swallow) bytes; a byte with bit8=1 is the tail, and the FSM returns to IDLE after it.
- A minimum packet is 2 bytes. Head and tail in one byte is not supported; such a byte is treated as a head.
- Per-flow counters are a `FLOW_NUM`×`CNT_W` register array. `i_period_sync` clears all counters.
- Counters never exceed `iv_ts_limit` and never wrap.
- Flow id bits above `FLOW_ID_W` are ignored.
- `iv_ts_limit`=0 drops every TS packet.
- `i_data_wr` deasserted mid-packet: state is held and no output is produced.

## Timing
- All outputs registered; data latency is exactly 1 cycle from input byte to `o_data_wr`/`o_nmac_data_wr`.
- Pulses (`o_pkt_cnt_pulse`, `o_pkt_discard_pulse`, `o_ts_overflow_error_pulse`) assert 1 cycle after the head byte, for one cycle.
- Simultaneous `i_period_sync` and TS head: the clear applies first, the packet is admitted, and its counter ends at 1 (0 if limit=0).
- Thresholds are sampled only on the head cycle; changes mid-packet do not affect that packet.
- Reset values:
  - all outputs 0;
  - `ov_pad_state`=IDLE;
  - counters 0;
  - `ov_overflow_flow_id`=0.
- Reset asserted mid-packet returns to IDLE immediately. The remaining bytes of that packet are then ignored until the next bit8=1 byte, which is taken as a head.

## Configuration
- `PAD_PER_FLOW_LIMIT_EN` defined: adds ports `iv_limit_cfg` (CNT_W), `iv_limit_cfg_addr` (FLOW_ID_W) and `i_limit_cfg_wr`.
  - These write a per-flow limit array; reset value of every entry is all-ones.
  - TS policing compares against limit[flow], and `iv_ts_limit` is unused.
  - A config write to the flow whose head is being decided in the same cycle takes effect from the next packet.
- Undefined: single global `iv_ts_limit`, no config ports.

## Test plan
- TS flow 3, limit=2, three 64-byte packets in one period -> first two forwarded byte-for-byte 1 cycle late; third dropped with `o_pkt_discard_pulse`=1, `o_ts_overflow_error_pulse`=1 and `ov_overflow_flow_id`=3.
- Same stream with `i_period_sync` on the third head -> all three forwarded; cnt[3]=1 afterwards.
- BE packet, rdusedw=10, be_threshold=10 -> dropped; rdusedw=11 -> forwarded. RC packet with rc_threshold=5, rdusedw=6 -> forwarded.
- NMAC packet of 60 bytes -> appears only on `ov_nmac_data`; `o_data_wr` stays 0; `o_pkt_cnt_pulse`=1 once.
- `i_rst_n` low at byte 20 of a forwarded packet, released, then the rest of the packet, then a new TS packet -> no output until the new head is accepted; all pulses and outputs are 0 during reset.
- With `PAD_PER_FLOW_LIMIT_EN`: set flow 7 limit=1 and flow 8 limit=0 -> flow 7 gets 1 packet admitted per period, flow 8 gets none, flow 9 (limit all-ones) gets 255.

Source files
------------

// File: rtl/packet_admission_dispatch.sv
// Host RX packet classifier, TS flow policer and TS/RC/BE vs NMAC dispatcher.
// Define PAD_PER_FLOW_LIMIT_EN for a writable per-flow TS limit table.
module packet_admission_dispatch #(
    parameter int FLOW_NUM  = 32,
    parameter int FLOW_ID_W = 5,
    parameter int CNT_W     = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [8:0]           iv_data,
    input  logic                 i_data_wr,
    input  logic [18:0]          iv_ctrl_data,
    input  logic                 i_period_sync,
    input  logic [CNT_W-1:0]     iv_ts_limit,
    input  logic [8:0]           iv_free_bufid_fifo_rdusedw,
    input  logic [8:0]           iv_rc_threshold_value,
    input  logic [8:0]           iv_be_threshold_value,
`ifdef PAD_PER_FLOW_LIMIT_EN
    input  logic [CNT_W-1:0]     iv_limit_cfg,
    input  logic [FLOW_ID_W-1:0] iv_limit_cfg_addr,
    input  logic                 i_limit_cfg_wr,
`endif
    output logic [8:0]           ov_data,
    output logic                 o_data_wr,
    output logic [18:0]          ov_ctrl_data,
    output logic [8:0]           ov_nmac_data,
    output logic                 o_nmac_data_wr,
    output logic                 o_pkt_cnt_pulse,
    output logic                 o_pkt_discard_pulse,
    output logic                 o_ts_overflow_error_pulse,
    output logic [FLOW_ID_W-1:0] ov_overflow_flow_id,
    output logic [1:0]           ov_pad_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_FWD  = 2'b01,
        S_NMAC = 2'b10,
        S_DROP = 2'b11
    } state_t;

    state_t r_state;
    state_t w_nxt_state;

    logic [CNT_W-1:0]     r_cnt [FLOW_NUM];
    logic [FLOW_ID_W-1:0] w_flow;
    logic [2:0]           w_type;
    logic                 w_is_ts;
    logic                 w_is_rc;
    logic                 w_is_nmac;
    logic [CNT_W-1:0]     w_limit;
    logic [CNT_W-1:0]     w_cnt_cur;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_ts_ok;
    logic                 w_buf_ok;
    logic                 w_head;
    logic                 w_fwd;
    logic                 w_nmac;
    logic                 w_drop;
    logic                 w_ovf;
    logic                 w_cnt_inc;

    assign w_type    = iv_ctrl_data[18:16];
    assign w_flow    = iv_ctrl_data[FLOW_ID_W-1:0];
    assign w_is_ts   = (w_type == 3'b000);
    assign w_is_rc   = (w_type == 3'b001);
    assign w_is_nmac = (w_type == 3'b011);

`ifdef PAD_PER_FLOW_LIMIT_EN
    logic [CNT_W-1:0] r_limit [FLOW_NUM];
    logic             w_unused_ts_limit;

    assign w_unused_ts_limit = ^iv_ts_limit;
    assign w_limit           = r_limit[w_flow];

    // Written after the head decision reads it, so a same-cycle write hits the next packet.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FLOW_NUM; i++) r_limit[i] <= '1;
        end else if (i_limit_cfg_wr) begin
            r_limit[iv_limit_cfg_addr] <= iv_limit_cfg;
        end
    end
`else
    assign w_limit = iv_ts_limit;
`endif

    // A period sync in the head cycle clears first, so the packet sees a zero count.
    assign w_cnt_cur = i_period_sync ? '0 : r_cnt[w_flow];
    assign w_cnt_nxt = w_cnt_cur + {{(CNT_W-1){1'b0}}, 1'b1};
    assign w_ts_ok   = (w_cnt_cur < w_limit);
    assign w_buf_ok  = w_is_rc ?
                       (iv_free_bufid_fifo_rdusedw > iv_rc_threshold_value) :
                       (iv_free_bufid_fifo_rdusedw > iv_be_threshold_value);

    always_comb begin
        w_nxt_state = r_state;
        w_head      = 1'b0;
        w_fwd       = 1'b0;
        w_nmac      = 1'b0;
        w_drop      = 1'b0;
        w_ovf       = 1'b0;
        w_cnt_inc   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_data_wr && iv_data[8]) begin
                    w_head = 1'b1;
                    unique case (1'b1)
                        w_is_nmac: begin
                            w_nxt_state = S_NMAC;
                            w_nmac      = 1'b1;
                        end
                        w_is_ts: begin
                            if (w_ts_ok) begin
                                w_nxt_state = S_FWD;
                                w_fwd       = 1'b1;
                                w_cnt_inc   = 1'b1;
                            end else begin
                                w_nxt_state = S_DROP;
                                w_drop      = 1'b1;
                                w_ovf       = 1'b1;
                            end
                        end
                        default: begin
                            if (w_buf_ok) begin
                                w_nxt_state = S_FWD;
                                w_fwd       = 1'b1;
                            end else begin
                                w_nxt_state = S_DROP;
                                w_drop      = 1'b1;
                            end
                        end
                    endcase
                end
            end
            S_FWD: begin
                if (i_data_wr) begin
                    w_fwd = 1'b1;
                    if (iv_data[8]) w_nxt_state = S_IDLE;
                end
            end
            S_NMAC: begin
                if (i_data_wr) begin
                    w_nmac = 1'b1;
                    if (iv_data[8]) w_nxt_state = S_IDLE;
                end
            end
            S_DROP: begin
                if (i_data_wr && iv_data[8]) w_nxt_state = S_IDLE;
            end
            default: w_nxt_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FLOW_NUM; i++) r_cnt[i] <= '0;
        end else begin
            if (i_period_sync) begin
                for (int i = 0; i < FLOW_NUM; i++) r_cnt[i] <= '0;
            end
            if (w_cnt_inc) r_cnt[w_flow] <= w_cnt_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ov_data                   <= '0;
            o_data_wr                 <= 1'b0;
            ov_ctrl_data              <= '0;
            ov_nmac_data              <= '0;
            o_nmac_data_wr            <= 1'b0;
            o_pkt_cnt_pulse           <= 1'b0;
            o_pkt_discard_pulse       <= 1'b0;
            o_ts_overflow_error_pulse <= 1'b0;
            ov_overflow_flow_id       <= '0;
        end else begin
            o_data_wr                 <= w_fwd;
            o_nmac_data_wr            <= w_nmac;
            o_pkt_cnt_pulse           <= w_head;
            o_pkt_discard_pulse       <= w_drop;
            o_ts_overflow_error_pulse <= w_ovf;
            if (w_fwd)  ov_data      <= iv_data;
            if (w_nmac) ov_nmac_data <= iv_data;
            if (w_head) ov_ctrl_data <= iv_ctrl_data;
            if (w_ovf)  ov_overflow_flow_id <= w_flow;
        end
    end

    assign ov_pad_state = r_state;

endmodule

// File: tb/tb_packet_admission_dispatch.sv
// Randomised scoreboard bench for packet_admission_dispatch.
// Build with PAD_PER_FLOW_LIMIT_EN to also cover the per-flow limit table.
module tb_packet_admission_dispatch;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic [8:0]  iv_data;
    logic        i_data_wr;
    logic [18:0] iv_ctrl_data;
    logic        i_period_sync;
    logic [7:0]  iv_ts_limit;
    logic [8:0]  iv_free_bufid_fifo_rdusedw;
    logic [8:0]  iv_rc_threshold_value;
    logic [8:0]  iv_be_threshold_value;
`ifdef PAD_PER_FLOW_LIMIT_EN
    logic [7:0]  iv_limit_cfg;
    logic [4:0]  iv_limit_cfg_addr;
    logic        i_limit_cfg_wr;
`endif
    logic [8:0]  ov_data;
    logic        o_data_wr;
    logic [18:0] ov_ctrl_data;
    logic [8:0]  ov_nmac_data;
    logic        o_nmac_data_wr;
    logic        o_pkt_cnt_pulse;
    logic        o_pkt_discard_pulse;
    logic        o_ts_overflow_error_pulse;
    logic [4:0]  ov_overflow_flow_id;
    logic [1:0]  ov_pad_state;

    always #5 clk = ~clk;

    packet_admission_dispatch #(
        .FLOW_NUM(32), .FLOW_ID_W(5), .CNT_W(8)
    ) dut (
        .i_clk(clk),
        .i_rst_n(i_rst_n),
        .iv_data(iv_data),
        .i_data_wr(i_data_wr),
        .iv_ctrl_data(iv_ctrl_data),
        .i_period_sync(i_period_sync),
        .iv_ts_limit(iv_ts_limit),
        .iv_free_bufid_fifo_rdusedw(iv_free_bufid_fifo_rdusedw),
        .iv_rc_threshold_value(iv_rc_threshold_value),
        .iv_be_threshold_value(iv_be_threshold_value),
`ifdef PAD_PER_FLOW_LIMIT_EN
        .iv_limit_cfg(iv_limit_cfg),
        .iv_limit_cfg_addr(iv_limit_cfg_addr),
        .i_limit_cfg_wr(i_limit_cfg_wr),
`endif
        .ov_data(ov_data),
        .o_data_wr(o_data_wr),
        .ov_ctrl_data(ov_ctrl_data),
        .ov_nmac_data(ov_nmac_data),
        .o_nmac_data_wr(o_nmac_data_wr),
        .o_pkt_cnt_pulse(o_pkt_cnt_pulse),
        .o_pkt_discard_pulse(o_pkt_discard_pulse),
        .o_ts_overflow_error_pulse(o_ts_overflow_error_pulse),
        .ov_overflow_flow_id(ov_overflow_flow_id),
        .ov_pad_state(ov_pad_state)
    );

    typedef struct packed {
        logic [8:0]  d;
        logic [18:0] c;
    } byte_exp_t;

    typedef struct packed {
        logic       dis;
        logic       ovf;
        logic [4:0] id;
    } head_exp_t;

    byte_exp_t q_data[$];
    byte_exp_t q_nmac[$];
    head_exp_t q_head[$];

    int total = 0;
    int bad   = 0;

    // Reference model: packet disposition decided from the rules at each head.
    int          m_cnt [32];
    int          m_lim [32];
    bit          m_in;
    int          m_disp;
    logic [18:0] m_ctrl;

    logic [8:0]  s_rdused, s_rc, s_be;
    logic [7:0]  s_lim;
    bit          s_cfg_wr;
    logic [4:0]  s_cfg_addr;
    logic [7:0]  s_cfg_val;
    bit          rnd_mode;

    task automatic check(input string n, input logic [63:0] a,
                         input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask

    task automatic model_reset();
        m_in = 1'b0;
        for (int i = 0; i < 32; i++) begin
            m_cnt[i] = 0;
            m_lim[i] = 255;
        end
    endtask

    task automatic step(input logic wr, input logic [8:0] d,
                        input logic [18:0] c, input logic sync_in);
        logic sync;
        int   fl;
        int   ty;
        int   lim;
        bit   ok;
        sync = sync_in;
        @(negedge clk);
        if (rnd_mode) begin
            s_rdused = 9'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) sync = 1'b1;
`ifdef PAD_PER_FLOW_LIMIT_EN
            if ($urandom_range(0, 9) == 0) begin
                s_cfg_wr   = 1'b1;
                s_cfg_addr = 5'($urandom_range(0, 3));
                s_cfg_val  = 8'($urandom_range(0, 3));
            end
`endif
        end
        i_data_wr     = wr;
        iv_data       = d;
        iv_ctrl_data  = c;
        i_period_sync = sync;
        iv_ts_limit   = s_lim;
        iv_free_bufid_fifo_rdusedw = s_rdused;
        iv_rc_threshold_value      = s_rc;
        iv_be_threshold_value      = s_be;
`ifdef PAD_PER_FLOW_LIMIT_EN
        i_limit_cfg_wr    = s_cfg_wr;
        iv_limit_cfg_addr = s_cfg_addr;
        iv_limit_cfg      = s_cfg_val;
`endif
        if (sync) for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        if (wr) begin
            if (!m_in) begin
                if (d[8]) begin
                    m_in   = 1'b1;
                    m_ctrl = c;
                    fl     = int'(c[4:0]);
                    ty     = int'(c[18:16]);
                    if (ty == 3) begin
                        m_disp = 1;
                        q_nmac.push_back({d, c});
                        q_head.push_back(7'b0);
                    end else begin
                        if (ty == 0) begin
`ifdef PAD_PER_FLOW_LIMIT_EN
                            lim = m_lim[fl];
`else
                            lim = int'(s_lim);
`endif
                            ok = (m_cnt[fl] < lim);
                            if (ok) m_cnt[fl]++;
                        end else if (ty == 1) begin
                            ok = (s_rdused > s_rc);
                        end else begin
                            ok = (s_rdused > s_be);
                        end
                        m_disp = ok ? 0 : 2;
                        if (ok) q_data.push_back({d, c});
                        q_head.push_back({~ok, (ty == 0) && !ok, c[4:0]});
                    end
                end
            end else begin
                if (m_disp == 0) q_data.push_back({d, m_ctrl});
                else if (m_disp == 1) q_nmac.push_back({d, m_ctrl});
                if (d[8]) m_in = 1'b0;
            end
        end
`ifdef PAD_PER_FLOW_LIMIT_EN
        if (s_cfg_wr) m_lim[s_cfg_addr] = int'(s_cfg_val);
`endif
        s_cfg_wr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 9'h0, 19'h0, 1'b0);
    endtask

    task automatic send_pkt(input logic [18:0] c, input int len,
                            input logic sync_head, input bit gaps);
        step(1'b1, {1'b1, 8'($urandom)}, c, sync_head);
        for (int i = 1; i < len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0)
                step(1'b0, 9'($urandom), 19'($urandom), 1'b0);
            step(1'b1, {(i == len - 1), 8'($urandom)}, 19'($urandom), 1'b0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_data_wr     = 1'b0;
        i_period_sync = 1'b0;
        i_rst_n       = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        i_rst_n = 1'b1;
    endtask

    function automatic logic [18:0] ctl(input int ty, input int fl);
        return {3'(ty), 11'($urandom), 5'(fl)};
    endfunction

    // Monitor: sample settled outputs shortly after each rising edge.
    always begin
        byte_exp_t eb;
        head_exp_t eh;
        @(posedge clk);
        #2;
        if (!i_rst_n) begin
            check("reset_outputs",
                  {15'b0, o_data_wr, o_nmac_data_wr, o_pkt_cnt_pulse,
                   o_pkt_discard_pulse, o_ts_overflow_error_pulse, ov_data,
                   ov_ctrl_data, ov_nmac_data, ov_pad_state,
                   ov_overflow_flow_id}, 64'h0);
        end else begin
            if (o_data_wr) begin
                if (q_data.size() == 0) begin
                    check("data_unexpected", {55'b0, ov_data}, 64'h1ff);
                end else begin
                    eb = q_data.pop_front();
                    check("data_byte", {55'b0, ov_data}, {55'b0, eb.d});
                    check("data_ctrl", {45'b0, ov_ctrl_data}, {45'b0, eb.c});
                end
            end
            if (o_nmac_data_wr) begin
                if (q_nmac.size() == 0) begin
                    check("nmac_unexpected", {55'b0, ov_nmac_data}, 64'h1ff);
                end else begin
                    eb = q_nmac.pop_front();
                    check("nmac_byte", {55'b0, ov_nmac_data}, {55'b0, eb.d});
                end
            end
            if (o_pkt_cnt_pulse) begin
                if (q_head.size() == 0) begin
                    check("head_unexpected", 64'h1, 64'h0);
                end else begin
                    eh = q_head.pop_front();
                    check("head_pulses",
                          {62'b0, o_pkt_discard_pulse, o_ts_overflow_error_pulse},
                          {62'b0, eh.dis, eh.ovf});
                    if (eh.ovf)
                        check("ovf_flow_id", {59'b0, ov_overflow_flow_id},
                              {59'b0, eh.id});
                end
            end else if (o_pkt_discard_pulse || o_ts_overflow_error_pulse) begin
                check("stray_pulse",
                      {62'b0, o_pkt_discard_pulse, o_ts_overflow_error_pulse},
                      64'h0);
            end
        end
    end

    initial begin
        i_rst_n = 1'b0;
        i_data_wr = 1'b0;
        iv_data = '0;
        iv_ctrl_data = '0;
        i_period_sync = 1'b0;
        iv_ts_limit = '0;
        iv_free_bufid_fifo_rdusedw = '0;
        iv_rc_threshold_value = '0;
        iv_be_threshold_value = '0;
`ifdef PAD_PER_FLOW_LIMIT_EN
        iv_limit_cfg = '0;
        iv_limit_cfg_addr = '0;
        i_limit_cfg_wr = 1'b0;
`endif
        s_rdused = 9'd100;
        s_rc = 9'd0;
        s_be = 9'd0;
        s_lim = 8'd2;
        s_cfg_wr = 1'b0;
        s_cfg_addr = '0;
        s_cfg_val = '0;
        rnd_mode = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        i_rst_n = 1'b1;
        idle(2);

`ifndef PAD_PER_FLOW_LIMIT_EN
        // TS budget: limit 2, third packet of flow 3 overflows.
        step(1'b0, 9'h0, 19'h0, 1'b1);
        for (int k = 0; k < 3; k++) send_pkt(ctl(0, 3), 64, 1'b0, 1'b0);
        idle(2);
        // Sync on third head: all admitted, then one more fits, next drops.
        step(1'b0, 9'h0, 19'h0, 1'b1);
        send_pkt(ctl(0, 3), 64, 1'b0, 1'b0);
        send_pkt(ctl(0, 3), 64, 1'b0, 1'b0);
        send_pkt(ctl(0, 3), 64, 1'b1, 1'b0);
        send_pkt(ctl(0, 3), 8, 1'b0, 1'b0);
        send_pkt(ctl(0, 3), 8, 1'b0, 1'b0);
        // Limit zero drops TS even with a same-cycle sync.
        s_lim = 8'd0;
        send_pkt(ctl(0, 9), 4, 1'b1, 1'b0);
        send_pkt(ctl(0, 9), 4, 1'b0, 1'b0);
        s_lim = 8'd2;
`endif
        // Buffer thresholds, strictly greater-than.
        s_be = 9'd10;
        s_rdused = 9'd10;
        send_pkt(ctl(2, 1), 6, 1'b0, 1'b0);
        s_rdused = 9'd11;
        send_pkt(ctl(2, 1), 6, 1'b0, 1'b1);
        s_rdused = 9'd10;
        send_pkt(ctl(7, 1), 6, 1'b0, 1'b0);
        s_rc = 9'd5;
        s_rdused = 9'd6;
        send_pkt(ctl(1, 2), 6, 1'b0, 1'b0);
        s_rdused = 9'd5;
        send_pkt(ctl(1, 2), 6, 1'b0, 1'b0);
        // NMAC split.
        send_pkt(ctl(3, 0), 60, 1'b0, 1'b1);
        idle(2);

        // Reset at byte 20 of a forwarded TS packet.
        s_lim = 8'd4;
        step(1'b0, 9'h0, 19'h0, 1'b1);
        step(1'b1, {1'b1, 8'h5a}, ctl(0, 4), 1'b0);
        for (int i = 1; i < 19; i++) step(1'b1, {1'b0, 8'(i)}, 19'h0, 1'b0);
        do_reset();
        for (int i = 19; i < 63; i++) step(1'b1, {1'b0, 8'(i)}, 19'h0, 1'b0);
        send_pkt(ctl(0, 5), 8, 1'b0, 1'b0);
        idle(2);

`ifdef PAD_PER_FLOW_LIMIT_EN
        s_cfg_wr = 1'b1; s_cfg_addr = 5'd7; s_cfg_val = 8'd1;
        idle(1);
        s_cfg_wr = 1'b1; s_cfg_addr = 5'd8; s_cfg_val = 8'd0;
        idle(1);
        step(1'b0, 9'h0, 19'h0, 1'b1);
        send_pkt(ctl(0, 7), 3, 1'b0, 1'b0);
        send_pkt(ctl(0, 7), 3, 1'b0, 1'b0);
        send_pkt(ctl(0, 8), 3, 1'b0, 1'b0);
        for (int k = 0; k < 256; k++) send_pkt(ctl(0, 9), 2, 1'b0, 1'b0);
        s_cfg_wr = 1'b1; s_cfg_addr = 5'd10; s_cfg_val = 8'd0;
        send_pkt(ctl(0, 10), 3, 1'b0, 1'b0);
        send_pkt(ctl(0, 10), 3, 1'b0, 1'b0);
        idle(2);
`endif

        // Randomised traffic with gaps, stray idle bytes, syncs and limit changes.
        rnd_mode = 1'b1;
        for (int k = 0; k < 300; k++) begin
            s_lim = 8'($urandom_range(0, 3));
            s_rc  = 9'($urandom_range(0, 15));
            s_be  = 9'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0)
                step(1'b1, {1'b0, 8'($urandom)}, 19'($urandom), 1'b0);
            send_pkt(ctl($urandom_range(0, 7), $urandom_range(0, 3)),
                     $urandom_range(2, 8), 1'b0, 1'b1);
        end
        rnd_mode = 1'b0;
        idle(5);

        check("data_queue_drained", 64'(q_data.size()), 64'h0);
        check("nmac_queue_drained", 64'(q_nmac.size()), 64'h0);
        check("head_queue_drained", 64'(q_head.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
